fpu_addsub_param: RTL and testbench

Parametrised multi-cycle floating-point adder/subtractor: next generation of the team's fixed 32-bit (1/6/25) FPU adder.
- Adds configurable exponent/mantissa widths, an add/sub select, valid/ready handshakes on both sides, round-to-nearest-even with guard/round/sticky bits, and one-hot status.
- Sits between operand-issue logic and the result writeback path; one operation in flight.

---
 rtl/fpu_pkg.sv | 41 ++++
 rtl/fpu_lzc.sv | 23 ++
 rtl/fpu_addsub.sv | 213 +++++++++++++++++++++
 tb/tb_fpu_addsub_param.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the parametrised FP adder/subtractor.
//   state_t        : sequencer states, one operation in flight
//   ST_*           : bit positions inside the one-hot status word
//   bias_of/word_w : format helpers derived from exponent/fraction widths
//   exp_ones       : exponent value that encodes infinity
package fpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  localparam int ST_EXACT     = 0;
  localparam int ST_OVERFLOW  = 1;
  localparam int ST_UNDERFLOW = 2;
  localparam int ST_INEXACT   = 3;
  localparam int STATUS_W     = 4;

  localparam logic [STATUS_W-1:0] STATUS_NONE = '0;

  function automatic int bias_of(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int word_w(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  function automatic int exp_ones(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  function automatic logic [STATUS_W-1:0] status_onehot(input int idx);
    return STATUS_W'(1) << idx;
  endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter.
//   vec  : field to scan, MSB first
//   cnt  : number of zeros above the most significant set bit (WIDTH if none)
//   zero : vec is all zeros
module fpu_lzc #(
  parameter  int WIDTH = 27,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  // Scan upward so the highest set bit is the last to write cnt.
  always_comb begin
    cnt  = CNT_W'(WIDTH);
    zero = ~|vec;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) cnt = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fpu_addsub.sv
// Multi-cycle floating-point adder/subtractor, {sign, exp, frac} format with
// hidden one, exp==0 is zero, exp==all-ones is infinity, no NaN.
// Round to nearest even on guard/round/sticky.
//   clock, reset          : rising-edge clock, async active-high reset
//   in_valid/in_ready     : operand handshake, accepted only in IDLE
//   op_sub                : 1 selects A-B (B sign flipped at capture)
//   op_A_in/op_B_in       : operands
//   out_valid/out_ready   : result handshake, result held until taken
//   data_out              : result word
//   status_out            : one-hot {INEXACT, UNDERFLOW, OVERFLOW, EXACT}
module fpu_addsub_param
  import fpu_pkg::*;
#(
  parameter  int EXP_W = 6,
  parameter  int MAN_W = 25,
  localparam int W     = word_w(EXP_W, MAN_W)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                op_sub,
  input  logic [W-1:0]        op_A_in,
  input  logic [W-1:0]        op_B_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W-1:0]        data_out,
  output logic [STATUS_W-1:0] status_out
);

  localparam int SIG_W   = MAN_W + 1;       // hidden one + fraction
  localparam int EXT_W   = SIG_W + 3;       // plus guard, round, sticky
  localparam int SUM_W   = EXT_W + 1;       // plus carry
  localparam int LZ_W    = MAN_W + 2;       // hidden, fraction, guard
  localparam int CNT_W   = $clog2(LZ_W + 1);
  localparam int XE_W    = ((EXP_W > CNT_W) ? EXP_W : CNT_W) + 2;
  localparam int EXP_MAX = exp_ones(EXP_W);
  localparam logic [EXP_W-1:0] EXP_ONES = EXP_W'(EXP_MAX);

  state_t state;

  // captured operands (B already carries the effective sign)
  logic             a_s, b_s;
  logic [EXP_W-1:0] a_e, b_e;
  logic [MAN_W-1:0] a_f, b_f;

  // pipeline of working values, one stage per state
  logic                   r_sign, eff_sub;
  logic [EXP_W-1:0]       r_exp;
  logic [EXT_W-1:0]       big_sig, small_sig;
  logic [SUM_W-1:0]       sum;
  logic signed [XE_W-1:0] n_exp;
  logic [EXT_W-1:0]       n_mant;
  logic                   n_zero;

  // ---------------------------------------------------------------- align
  logic             swap, al_big_s, al_small_s;
  logic [EXP_W-1:0] al_big_e, al_diff;
  logic [SIG_W-1:0] al_big_sig, al_small_sig;
  logic [EXT_W-1:0] al_small_ext, al_shifted;

  always_comb begin
    // {exp, frac} compares as magnitude because exp sits above frac
    swap         = {b_e, b_f} > {a_e, a_f};
    al_big_s     = swap ? b_s : a_s;
    al_small_s   = swap ? a_s : b_s;
    al_big_e     = swap ? b_e : a_e;
    al_big_sig   = swap ? {|b_e, b_f} : {|a_e, a_f};
    al_small_sig = swap ? {|a_e, a_f} : {|b_e, b_f};
    al_diff      = al_big_e - (swap ? a_e : b_e);
    al_small_ext = {al_small_sig, 3'b000};
    if (32'(al_diff) >= 32'(EXT_W - 1))
      al_shifted = {{(EXT_W-1){1'b0}}, |al_small_ext};
    else
      al_shifted = (al_small_ext >> al_diff)
                 | EXT_W'(|(al_small_ext & ~({EXT_W{1'b1}} << al_diff)));
  end

  // ----------------------------------------------------------------- norm
  // With exponent gap >= 2 a subtraction loses at most one bit of
  // magnitude, and with gap <= 1 round/sticky stay clear, so scanning
  // hidden..guard is enough to find the leading one or detect zero.
  logic [CNT_W-1:0] lz_cnt;
  logic             lz_zero;

  fpu_lzc #(.WIDTH(LZ_W)) u_lzc (
    .vec  (sum[EXT_W-1:2]),
    .cnt  (lz_cnt),
    .zero (lz_zero)
  );

  // ---------------------------------------------------------------- round
  logic                   rnd_g, rnd_r, rnd_s, rnd_up, a_inf, b_inf;
  logic [SIG_W:0]         rnd_mant;
  logic signed [XE_W-1:0] f_exp;
  logic [MAN_W-1:0]       f_frac;
  logic [W-1:0]           res_data;
  logic [STATUS_W-1:0]    res_status;

  always_comb begin
    rnd_g    = n_mant[2];
    rnd_r    = n_mant[1];
    rnd_s    = n_mant[0];
    rnd_up   = rnd_g & (rnd_r | rnd_s | n_mant[3]);
    rnd_mant = {1'b0, n_mant[EXT_W-1:3]} + (SIG_W+1)'(rnd_up);
    f_exp    = n_exp + XE_W'(rnd_mant[SIG_W]);
    // a mantissa carry-out leaves the fraction all zero either way
    f_frac   = rnd_mant[SIG_W] ? rnd_mant[MAN_W:1] : rnd_mant[MAN_W-1:0];
    a_inf    = &a_e;
    b_inf    = &b_e;
    if (a_inf | b_inf) begin
      // inf + (-inf) resolves to A's infinity
      res_data   = {a_inf ? a_s : b_s, EXP_ONES, {MAN_W{1'b0}}};
      res_status = status_onehot(ST_OVERFLOW);
    end else if (n_zero) begin
      res_data   = '0;
      res_status = status_onehot(ST_EXACT);
    end else if (f_exp >= $signed(XE_W'(EXP_MAX))) begin
      res_data   = {r_sign, EXP_ONES, {MAN_W{1'b0}}};
      res_status = status_onehot(ST_OVERFLOW);
    end else if (f_exp[XE_W-1] | ~|f_exp) begin
      res_data   = {r_sign, {(W-1){1'b0}}};
      res_status = status_onehot(ST_UNDERFLOW);
    end else begin
      res_data   = {r_sign, f_exp[EXP_W-1:0], f_frac};
      res_status = (rnd_g | rnd_r | rnd_s) ? status_onehot(ST_INEXACT)
                                           : status_onehot(ST_EXACT);
    end
  end

  // ------------------------------------------------------------ sequencer
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      data_out   <= '0;
      status_out <= STATUS_NONE;
      a_s        <= 1'b0;
      a_e        <= '0;
      a_f        <= '0;
      b_s        <= 1'b0;
      b_e        <= '0;
      b_f        <= '0;
      r_sign     <= 1'b0;
      eff_sub    <= 1'b0;
      r_exp      <= '0;
      big_sig    <= '0;
      small_sig  <= '0;
      sum        <= '0;
      n_exp      <= '0;
      n_mant     <= '0;
      n_zero     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            // nonzero fractions under a zero exponent flush to zero
            a_s      <= op_A_in[W-1];
            a_e      <= op_A_in[W-2 -: EXP_W];
            a_f      <= (op_A_in[W-2 -: EXP_W] == '0) ? '0 : op_A_in[MAN_W-1:0];
            b_s      <= op_B_in[W-1] ^ op_sub;
            b_e      <= op_B_in[W-2 -: EXP_W];
            b_f      <= (op_B_in[W-2 -: EXP_W] == '0) ? '0 : op_B_in[MAN_W-1:0];
            in_ready <= 1'b0;
            state    <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          r_sign    <= al_big_s;
          r_exp     <= al_big_e;
          big_sig   <= {al_big_sig, 3'b000};
          small_sig <= al_shifted;
          eff_sub   <= al_big_s ^ al_small_s;
          state     <= S_ADD;
        end
        S_ADD: begin
          // big >= small after alignment, so the difference never wraps
          sum   <= eff_sub ? ({1'b0, big_sig} - {1'b0, small_sig})
                           : ({1'b0, big_sig} + {1'b0, small_sig});
          state <= S_NORM;
        end
        S_NORM: begin
          if (sum[SUM_W-1]) begin
            n_mant <= {sum[SUM_W-1:2], sum[1] | sum[0]};
            n_exp  <= XE_W'(r_exp) + XE_W'(1);
            n_zero <= 1'b0;
          end else begin
            n_mant <= sum[EXT_W-1:0] << lz_cnt;
            n_exp  <= XE_W'(r_exp) - XE_W'(lz_cnt);
            n_zero <= lz_zero;
          end
          state <= S_ROUND;
        end
        S_ROUND: begin
          data_out   <= res_data;
          status_out <= res_status;
          out_valid  <= 1'b1;
          state      <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_addsub_param.sv
// Self-checking bench for fpu_addsub_param at default widths (1/6/25).
module tb_fpu_addsub_param;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        op_sub = 1'b0;
  logic [31:0] op_A_in = '0;
  logic [31:0] op_B_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] data_out;
  logic [3:0]  status_out;

  int tests = 0;
  int fails = 0;

  fpu_addsub_param #(.EXP_W(6), .MAN_W(25)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_sub     (op_sub),
    .op_A_in    (op_A_in),
    .op_B_in    (op_B_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .data_out   (data_out),
    .status_out (status_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
  endtask

  // Reference: exact rational sum as a wide integer, then RNE to 26
  // significant bits, then range classification.
  function automatic void ref_model(input logic [31:0] a, input logic [31:0] b,
                                    input logic sub, output logic [31:0] d,
                                    output logic [3:0] st);
    int ea, eb, emin, p, e_res, sh;
    logic sa, sb, s, up;
    logic [127:0] ma, mb, mag, q, rem, half;
    sa = a[31];
    sb = b[31] ^ sub;
    ea = int'(a[30:25]);
    eb = int'(b[30:25]);
    if (ea == 63 || eb == 63) begin
      d  = {(ea == 63) ? sa : sb, 6'h3f, 25'h0};
      st = 4'b0010;
      return;
    end
    ma   = (ea == 0) ? 128'd0 : 128'({1'b1, a[24:0]});
    mb   = (eb == 0) ? 128'd0 : 128'({1'b1, b[24:0]});
    emin = (ea < eb) ? ea : eb;
    ma   = ma << (ea - emin);
    mb   = mb << (eb - emin);
    if (sa == sb) begin
      mag = ma + mb; s = sa;
    end else if (ma >= mb) begin
      mag = ma - mb; s = sa;
    end else begin
      mag = mb - ma; s = sb;
    end
    if (mag == 0) begin
      d = 32'h0; st = 4'b0001;
      return;
    end
    p = 0;
    for (int i = 0; i < 128; i++) if (mag[i]) p = i;
    e_res = p + emin - 25;
    rem = 0;
    if (p > 25) begin
      sh   = p - 25;
      q    = mag >> sh;
      rem  = mag & ((128'd1 << sh) - 1);
      half = 128'd1 << (sh - 1);
      up   = (rem > half) || (rem == half && q[0]);
      q    = q + 128'(up);
    end else begin
      q = mag << (25 - p);
    end
    if (q == (128'd1 << 26)) begin
      q = q >> 1; e_res++;
    end
    if (e_res >= 63) begin
      d = {s, 6'h3f, 25'h0}; st = 4'b0010;
    end else if (e_res <= 0) begin
      d = {s, 31'h0}; st = 4'b0100;
    end else begin
      d  = {s, 6'(e_res), q[24:0]};
      st = (rem != 0) ? 4'b1000 : 4'b0001;
    end
  endfunction

  // Waits, sampling on falling edges, until out_valid; n is the cycle index
  // with the acceptance cycle as 0. Bounded so a stuck DUT still finishes.
  task automatic wait_valid(output int n);
    n = 1;
    while (!out_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic [31:0] ed, input logic [3:0] es, input string tag);
    int n;
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    op_A_in  = a;
    op_B_in  = b;
    op_sub   = sub;
    in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    op_A_in  = $urandom;
    op_B_in  = $urandom;
    op_sub   = 1'($urandom);
    wait_valid(n);
    check({tag, ".latency"}, 32'(n), 32'd5);
    check({tag, ".data"}, data_out, ed);
    check({tag, ".status"}, 32'(status_out), 32'(es));
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    out_ready = 1'b0;
    check({tag, ".valid_clr"}, 32'(out_valid), 32'd0);
    check({tag, ".data_hold"}, data_out, ed);
  endtask

  initial begin
    logic [31:0] ra, rb, ed;
    logic [3:0]  es;
    logic        rs, seen;
    int          ea, eb, sel, n;

    // reset state
    #2 reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.data", data_out, 32'd0);
    check("rst.status", 32'(status_out), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // directed vectors
    run_op(32'hBE000000, 32'hBE000000, 1'b0, 32'hC0000000, 4'b0001, "neg1_plus_neg1");
    run_op(32'h40000000, 32'h42000000, 1'b1, 32'hC0000000, 4'b0001, "two_minus_four");
    run_op(32'h3E000000, 32'hBE000000, 1'b0, 32'h00000000, 4'b0001, "cancel_zero");
    run_op(32'h3E000000, 32'h0A000000, 1'b0, 32'h3E000000, 4'b1000, "tie_even");
    run_op(32'h7DFFFFFF, 32'h7DFFFFFF, 1'b0, 32'h7E000000, 4'b0010, "overflow");
    run_op(32'h02000001, 32'h82000000, 1'b0, 32'h00000000, 4'b0100, "underflow");
    run_op(32'h3E000000, 32'h00000123, 1'b0, 32'h3E000000, 4'b0001, "flush_denorm");
    run_op(32'h7E000000, 32'hFE000000, 1'b0, 32'h7E000000, 4'b0010, "inf_minus_inf");
    run_op(32'h3E000000, 32'h7E000000, 1'b1, 32'hFE000000, 4'b0010, "sub_inf");
    run_op(32'h3F000000, 32'h40400000, 1'b0, 32'h41C00000, 4'b0001, "one5_plus_two25");

    // backpressure with a second operation pending
    op_A_in  = 32'h3F000000;
    op_B_in  = 32'h40400000;
    op_sub   = 1'b0;
    in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    op_A_in = 32'hBE000000;
    op_B_in = 32'hBE000000;
    wait_valid(n);
    check("bp.latency", 32'(n), 32'd5);
    for (int i = 0; i < 10; i++) begin
      check("bp.in_ready", 32'(in_ready), 32'd0);
      check("bp.out_valid", 32'(out_valid), 32'd1);
      check("bp.data", data_out, 32'h41C00000);
      check("bp.status", 32'(status_out), 32'd1);
      @(negedge clock);
    end
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    out_ready = 1'b0;
    check("bp.valid_clr", 32'(out_valid), 32'd0);
    check("bp.ready_back", 32'(in_ready), 32'd1);
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    check("bp.second_taken", 32'(in_ready), 32'd0);
    wait_valid(n);
    check("bp2.latency", 32'(n), 32'd5);
    check("bp2.data", data_out, 32'hC0000000);
    check("bp2.status", 32'(status_out), 32'd1);
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    out_ready = 1'b0;

    // reset while the operation sits in ADD
    op_A_in  = 32'hBE000000;
    op_B_in  = 32'hBE000000;
    op_sub   = 1'b0;
    in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("abort.out_valid", 32'(out_valid), 32'd0);
    check("abort.data", data_out, 32'd0);
    check("abort.in_ready", 32'(in_ready), 32'd1);
    check("abort.status", 32'(status_out), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (out_valid) seen = 1'b1;
    end
    check("abort.op_lost", 32'(seen), 32'd0);
    run_op(32'h3F000000, 32'h40400000, 1'b0, 32'h41C00000, 4'b0001, "after_reset");

    // randomized operands against the reference model
    for (int k = 0; k < 40; k++) begin
      ra  = $urandom;
      rb  = $urandom;
      ea  = int'($urandom_range(0, 63));
      sel = int'($urandom_range(0, 7));
      ra[30:25] = 6'(ea);
      if (sel < 4) begin
        eb = ea + int'($urandom_range(0, 6)) - 3;
        if (eb < 0) eb = 0;
        if (eb > 63) eb = 63;
        rb[30:25] = 6'(eb);
      end else if (sel == 4) begin
        rb = ra ^ 32'h80000000;
      end
      rs = 1'($urandom);
      ref_model(ra, rb, rs, ed, es);
      run_op(ra, rb, rs, ed, es, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
